// File: rtl/peripheral_hub.sv
// peripheral_hub: memory-mapped output ports, debounced active-low buttons, down-counter timer, irq.
// Optional feature macro PERIPH_TIMER_PRESCALE_EN adds the timer tick prescaler register at 0x07.
module peripheral_hub #(
  parameter int IOPORT_COUNT    = 2,
  parameter int IOPORT_WIDTH    = 8,
  parameter int BUTTON_COUNT    = 1,
  parameter int DEBOUNCE_CYCLES = 4096,
  parameter int TIMER_WIDTH     = 16
) (
  input  logic                                 raw_clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic [5:0]                           address,
  input  logic [15:0]                          data_in,
  input  logic                                 write_enable,
  output logic [15:0]                          data_out,
  output logic [IOPORT_COUNT*IOPORT_WIDTH-1:0] ioport,
  input  logic [BUTTON_COUNT-1:0]              button,
  output logic                                 irq
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [BUTTON_COUNT-1:0] r_sync1, r_sync2, r_db_state, r_flags, r_mask_btn;
  logic [DB_W-1:0]         r_db_cnt [BUTTON_COUNT];
  logic                    r_mask_tmr, r_irq;
  logic [TIMER_WIDTH-1:0]  r_reload, r_count;
  logic                    r_run, r_auto, r_expired;
  logic [IOPORT_WIDTH-1:0] r_ioport [IOPORT_COUNT];
  logic [15:0]             r_data_out;

  logic [BUTTON_COUNT-1:0] w_sync, w_db_rise, w_clr_flags;
  logic                    w_wr, w_rd, w_wr_flags, w_wr_mask, w_wr_reload, w_wr_ctrl;
  logic                    w_tick, w_expire;
  logic [15:0]             w_pre_rd, w_rd_data;

  assign w_wr        = enable & write_enable;
  assign w_rd        = enable & ~write_enable;
  assign w_wr_flags  = w_wr && (address == 6'h01);
  assign w_wr_mask   = w_wr && (address == 6'h02);
  assign w_wr_reload = w_wr && (address == 6'h04);
  assign w_wr_ctrl   = w_wr && (address == 6'h05);
  assign w_clr_flags = {BUTTON_COUNT{w_wr_flags}} & data_in[BUTTON_COUNT-1:0];

  // Sync flops carry the raw (active-low) pin so their idle value is 1; inversion happens after.
  assign w_sync = ~r_sync2;

  always_comb begin
    w_db_rise = '0;
    for (int b = 0; b < BUTTON_COUNT; b++)
      w_db_rise[b] = w_sync[b] & ~r_db_state[b] & (r_db_cnt[b] == DB_MAX);
  end

  always_ff @(posedge raw_clk or negedge reset) begin
    if (!reset) begin
      r_sync1    <= '1;
      r_sync2    <= '1;
      r_db_state <= '0;
      for (int b = 0; b < BUTTON_COUNT; b++) r_db_cnt[b] <= '0;
    end else begin
      r_sync1 <= button;
      r_sync2 <= r_sync1;
      for (int b = 0; b < BUTTON_COUNT; b++) begin
        if (w_sync[b] != r_db_state[b]) begin
          if (r_db_cnt[b] == DB_MAX) begin
            r_db_state[b] <= w_sync[b];
            r_db_cnt[b]   <= '0;
          end else begin
            r_db_cnt[b] <= r_db_cnt[b] + DB_W'(1);
          end
        end else begin
          r_db_cnt[b] <= '0;
        end
      end
    end
  end

`ifdef PERIPH_TIMER_PRESCALE_EN
  logic [7:0] r_prescale, r_pre_cnt;
  logic       w_wr_pre;

  assign w_wr_pre = w_wr && (address == 6'h07);
  assign w_tick   = (r_pre_cnt == r_prescale);
  assign w_pre_rd = {8'h00, r_prescale};

  always_ff @(posedge raw_clk or negedge reset) begin
    if (!reset) begin
      r_prescale <= '0;
      r_pre_cnt  <= '0;
    end else begin
      if (w_wr_pre) r_prescale <= data_in[7:0];
      if (w_wr_ctrl && data_in[0]) r_pre_cnt <= '0;
      else if (r_run)              r_pre_cnt <= w_tick ? 8'h00 : r_pre_cnt + 8'h01;
    end
  end
`else
  assign w_tick   = 1'b1;
  assign w_pre_rd = '0;
`endif

  // Expiry is judged on the pre-edge state, so it still lands on an edge that also writes control.
  assign w_expire = r_run & w_tick & (r_count == '0);

  always_ff @(posedge raw_clk or negedge reset) begin
    if (!reset) begin
      r_reload  <= '0;
      r_count   <= '0;
      r_run     <= 1'b0;
      r_auto    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      if (w_wr_reload) r_reload <= data_in[TIMER_WIDTH-1:0];
      if (w_wr_ctrl) begin
        r_run  <= data_in[0];
        r_auto <= data_in[1];
        if (data_in[0]) r_count <= r_reload;
      end else if (r_run && w_tick) begin
        if (r_count != '0)  r_count <= r_count - TIMER_WIDTH'(1);
        else if (r_auto)    r_count <= r_reload;
        else                r_run   <= 1'b0;
      end
      r_expired <= (r_expired & ~(w_wr_ctrl & data_in[2])) | w_expire;
    end
  end

  always_ff @(posedge raw_clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < IOPORT_COUNT; n++) r_ioport[n] <= '0;
    end else begin
      for (int n = 0; n < IOPORT_COUNT; n++)
        if (w_wr && (address == 6'(8 + n))) r_ioport[n] <= data_in[IOPORT_WIDTH-1:0];
    end
  end

  for (genvar n = 0; n < IOPORT_COUNT; n++) begin : g_port
    assign ioport[n*IOPORT_WIDTH +: IOPORT_WIDTH] = r_ioport[n];
  end

  always_comb begin
    w_rd_data = '0;
    case (address)
      6'h00: w_rd_data[BUTTON_COUNT-1:0] = r_db_state;
      6'h01: w_rd_data[BUTTON_COUNT-1:0] = r_flags;
      6'h02: begin
        w_rd_data[BUTTON_COUNT-1:0] = r_mask_btn;
        w_rd_data[15]               = r_mask_tmr;
      end
      6'h04: w_rd_data[TIMER_WIDTH-1:0] = r_reload;
      6'h05: w_rd_data[2:0] = {r_expired, r_auto, r_run};
      6'h06: w_rd_data[TIMER_WIDTH-1:0] = r_count;
      6'h07: w_rd_data = w_pre_rd;
      default: begin
        for (int n = 0; n < IOPORT_COUNT; n++)
          if (address == 6'(8 + n)) w_rd_data[IOPORT_WIDTH-1:0] = r_ioport[n];
      end
    endcase
  end

  always_ff @(posedge raw_clk or negedge reset) begin
    if (!reset) begin
      r_flags    <= '0;
      r_mask_btn <= '0;
      r_mask_tmr <= 1'b0;
      r_irq      <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_flags <= (r_flags & ~w_clr_flags) | w_db_rise;
      if (w_wr_mask) begin
        r_mask_btn <= data_in[BUTTON_COUNT-1:0];
        r_mask_tmr <= data_in[15];
      end
      r_irq <= (|(r_flags & r_mask_btn)) | (r_expired & r_mask_tmr);
      if (w_rd) r_data_out <= w_rd_data;
    end
  end

  assign data_out = r_data_out;
  assign irq      = r_irq;

endmodule

// File: tb/tb_peripheral_hub.sv
// Self-checking bench for peripheral_hub: read results are scoreboarded against expected values.
module tb_peripheral_hub;
  localparam int IOPORT_COUNT    = 2;
  localparam int IOPORT_WIDTH    = 8;
  localparam int BUTTON_COUNT    = 1;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int TIMER_WIDTH     = 16;

  logic        raw_clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        write_enable = 1'b0;
  logic [5:0]  address = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic [IOPORT_COUNT*IOPORT_WIDTH-1:0] ioport;
  logic [BUTTON_COUNT-1:0] button = '1;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [15:0] q_exp[$];
  logic [15:0] q_got[$];
  string       q_name[$];

  peripheral_hub #(
    .IOPORT_COUNT(IOPORT_COUNT), .IOPORT_WIDTH(IOPORT_WIDTH), .BUTTON_COUNT(BUTTON_COUNT),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .TIMER_WIDTH(TIMER_WIDTH)
  ) dut (
    .raw_clk(raw_clk), .reset(reset), .enable(enable), .address(address),
    .data_in(data_in), .write_enable(write_enable), .data_out(data_out),
    .ioport(ioport), .button(button), .irq(irq)
  );

  always #5 raw_clk = ~raw_clk;

  // Bus tasks are entered at a negedge; the operation happens on the following posedge.
  task automatic bus_write(input logic [5:0] a, input logic [15:0] d);
    enable = 1'b1; write_enable = 1'b1; address = a; data_in = d;
    @(negedge raw_clk);
    enable = 1'b0; write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [5:0] a, input logic [15:0] exp, input string nm);
    enable = 1'b1; write_enable = 1'b0; address = a;
    q_exp.push_back(exp);
    q_name.push_back(nm);
    @(negedge raw_clk);
    enable = 1'b0;
    q_got.push_back(data_out);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge raw_clk);
  endtask

  task automatic test_reset();
    logic [15:0] e, g;
    string nm;
    reset = 1'b0;
    idle(2);
    checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL reset_data_out: got %h expected 0000", data_out); end
    checks++; if (ioport !== '0) begin errors++; $display("FAIL reset_ioport: got %h expected 0000", ioport); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    reset = 1'b1;
    idle(1);
    bus_write(6'h08, 16'h00FF);
    bus_write(6'h04, 16'h0000);
    bus_write(6'h02, 16'h8000);
    bus_write(6'h05, 16'h0003);
    bus_read(6'h08, 16'h00FF, "pre_reset_port0");
    idle(2);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b expected 1", irq); end
    #2 reset = 1'b0;
    #1;
    checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL midrun_reset_data_out: got %h expected 0000", data_out); end
    checks++; if (ioport !== '0) begin errors++; $display("FAIL midrun_reset_ioport: got %h expected 0000", ioport); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midrun_reset_irq: got %b expected 0", irq); end
    @(negedge raw_clk);
    reset = 1'b1;
    bus_read(6'h05, 16'h0000, "post_reset_ctrl");
    bus_read(6'h06, 16'h0000, "post_reset_count");
    bus_read(6'h02, 16'h0000, "post_reset_mask");
    bus_read(6'h08, 16'h0000, "post_reset_port0");
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); g = q_got.pop_front(); nm = q_name.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s: data_out=%h expected %h", nm, g, e); end
    end
  endtask

  task automatic test_readback();
    logic [15:0] e, g;
    string nm;
    bus_write(6'h08, 16'h00A5);
    bus_write(6'h09, 16'h003C);
    bus_read(6'h08, 16'h00A5, "port0_readback");
    bus_read(6'h09, 16'h003C, "port1_readback");
    checks++; if (ioport !== 16'h3CA5) begin errors++; $display("FAIL ioport_bits: got %h expected 3ca5", ioport); end
    bus_write(6'h0A, 16'h0055);
    bus_write(6'h06, 16'h1234);
    bus_read(6'h0A, 16'h0000, "unmapped_port_read");
    bus_read(6'h03, 16'h0000, "undefined_addr_read");
    bus_read(6'h10, 16'h0000, "high_addr_read");
    bus_read(6'h06, 16'h0000, "ro_count_write_ignored");
    checks++; if (ioport !== 16'h3CA5) begin errors++; $display("FAIL ioport_after_ignored: got %h expected 3ca5", ioport); end
    bus_write(6'h08, 16'hBEEF);
    bus_read(6'h08, 16'h00EF, "port0_upper_bits_zero");
    bus_read(6'h00, 16'h0000, "idle_button_state");
    bus_read(6'h01, 16'h0000, "idle_event_flags");
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); g = q_got.pop_front(); nm = q_name.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s: data_out=%h expected %h", nm, g, e); end
    end
  endtask

  task automatic test_debounce();
    logic [15:0] e, g;
    string nm;
    button = '0;
    idle(2);
    button = '1;
    idle(10);
    bus_read(6'h00, 16'h0000, "glitch_state");
    bus_read(6'h01, 16'h0000, "glitch_flag");
    button = '0;
    idle(10);
    bus_read(6'h00, 16'h0001, "press_state");
    bus_read(6'h01, 16'h0001, "press_flag");
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); g = q_got.pop_front(); nm = q_name.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s: data_out=%h expected %h", nm, g, e); end
    end
  endtask

  task automatic test_w1c_irq();
    logic [15:0] e, g;
    string nm;
    bus_write(6'h02, 16'h0001);
    idle(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_pending: got %b expected 1", irq); end
    bus_write(6'h01, 16'h0001);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_on_clear_edge: got %b expected 1", irq); end
    idle(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_clear: got %b expected 0", irq); end
    bus_read(6'h01, 16'h0000, "flag_cleared");
    button = '1;
    idle(10);
    bus_read(6'h00, 16'h0000, "released_state");
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_on_release: got %b expected 0", irq); end
    // The clear write lands on the sixth edge after the pin falls, the edge the flag sets.
    button = '0;
    idle(5);
    bus_write(6'h01, 16'h0001);
    bus_read(6'h01, 16'h0001, "set_wins_flag");
    idle(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_set_wins: got %b expected 1", irq); end
    bus_write(6'h01, 16'h0001);
    bus_write(6'h02, 16'h0000);
    bus_read(6'h01, 16'h0000, "final_flag_clear");
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); g = q_got.pop_front(); nm = q_name.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s: data_out=%h expected %h", nm, g, e); end
    end
  endtask

  task automatic test_timer_oneshot();
    logic [15:0] e, g;
    string nm;
    bus_write(6'h04, 16'h0003);
    bus_write(6'h05, 16'h0001);
    for (int k = 0; k < 5; k++)
      bus_read(6'h05, (k < 4) ? 16'h0001 : 16'h0004, $sformatf("oneshot_ctrl_%0d", k));
    bus_read(6'h06, 16'h0000, "oneshot_final_count");
    bus_write(6'h05, 16'h0005);
    for (int k = 0; k < 5; k++)
      bus_read(6'h06, (k < 4) ? 16'(3 - k) : 16'h0000, $sformatf("oneshot_count_%0d", k));
    bus_read(6'h05, 16'h0004, "oneshot_ctrl_rerun");
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); g = q_got.pop_front(); nm = q_name.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s: data_out=%h expected %h", nm, g, e); end
    end
  endtask

  task automatic test_timer_auto();
    logic [15:0] e, g;
    string nm;
    bus_write(6'h04, 16'h0000);
    bus_write(6'h02, 16'h8000);
    bus_write(6'h05, 16'h0003);
    idle(2);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL auto_irq: got %b expected 1", irq); end
    bus_read(6'h05, 16'h0007, "auto_ctrl");
    bus_read(6'h06, 16'h0000, "auto_count");
    bus_write(6'h05, 16'h0007);
    bus_read(6'h05, 16'h0007, "auto_expired_set_wins");
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL auto_irq_after_w1c: got %b expected 1", irq); end
    bus_write(6'h05, 16'h0000);
    bus_write(6'h05, 16'h0004);
    bus_read(6'h05, 16'h0000, "stopped_ctrl");
    idle(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_stop: got %b expected 0", irq); end
    bus_read(6'h02, 16'h8000, "mask_readback");
    bus_write(6'h02, 16'h0000);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); g = q_got.pop_front(); nm = q_name.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s: data_out=%h expected %h", nm, g, e); end
    end
  endtask

  task automatic test_prescale();
    logic [15:0] e, g;
    string nm;
`ifdef PERIPH_TIMER_PRESCALE_EN
    bus_write(6'h07, 16'h0002);
    bus_read(6'h07, 16'h0002, "prescale_readback");
    bus_write(6'h04, 16'h0001);
    bus_write(6'h05, 16'h0001);
    for (int k = 0; k < 7; k++)
      bus_read(6'h05, (k < 6) ? 16'h0001 : 16'h0004, $sformatf("prescale_ctrl_%0d", k));
`else
    bus_write(6'h07, 16'h0002);
    bus_read(6'h07, 16'h0000, "prescale_absent");
`endif
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); g = q_got.pop_front(); nm = q_name.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s: data_out=%h expected %h", nm, g, e); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    @(negedge raw_clk);
    test_reset();
    test_readback();
    test_debounce();
    test_w1c_irq();
    test_timer_oneshot();
    test_timer_auto();
    test_prescale();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
